// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/load-store memory arbiter
package mem_arb_pkg;
  localparam int ARB_XLEN = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic [1:0] {NONE, INSTR, DATA} arb_owner_t;
  typedef struct packed {
    logic                  we;
    logic [ARB_XLEN/8-1:0] be;
    logic [ARB_XLEN-1:0]   addr;
    logic [ARB_XLEN-1:0]   wdata;
  } mem_req_t;
endpackage

// File: rtl/arb_streak_ctr.sv
// arb_streak_ctr: saturating count of data grants made while a fetch is waiting
module arb_streak_ctr #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_hit_o
);
  localparam int W = $clog2(MAX_STREAK + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign limit_hit_o = cnt_q == W'(MAX_STREAK);
  always_comb cnt_d = clr_i ? '0 : (inc_i && !limit_hit_o) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and load/store,
// data first with a streak limit so fetch cannot starve; one transaction outstanding.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = ARB_XLEN,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  input  logic            m_ready,
  output logic            m_we,
  output logic [XLEN/8-1:0] m_be,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata
);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  mem_req_t   req_q, req_d;
  logic       limit_hit, gnt_d, gnt_i;
  assign gnt_d = state_q == IDLE && d_req && (!i_req || !limit_hit);
  assign gnt_i = state_q == IDLE && !gnt_d && i_req;
  // the streak only grows while a fetch is actually being held off
  arb_streak_ctr #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc_i       (gnt_d && i_req),
    .clr_i       (gnt_i || (gnt_d && !i_req)),
    .limit_hit_o (limit_hit)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (gnt_d || gnt_i) begin
        state_d = ISSUE;
        owner_d = gnt_d ? DATA : INSTR;
        req_d   = gnt_d ? mem_req_t'{d_we, d_be, d_addr, d_wdata} : mem_req_t'{1'b0, '0, i_addr, '0};
      end
      ISSUE: state_d = m_ready ? WAIT : ISSUE;
      WAIT: if (m_rvalid) begin
        state_d = IDLE;
        owner_d = NONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= NONE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  assign m_req   = state_q == ISSUE;
  assign m_we    = req_q.we;
  assign m_be    = req_q.be;
  assign m_addr  = req_q.addr;
  assign m_wdata = req_q.wdata;
  assign i_ack   = m_rvalid && state_q == WAIT && owner_q == INSTR;
  assign d_ack   = m_rvalid && state_q == WAIT && owner_q == DATA;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter grant order, issue timing and response steering
module tb_mem_arbiter;
  localparam int XLEN = 32;
  logic clk = 0, reset_n = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [XLEN-1:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [XLEN/8-1:0] d_be = 0;
  logic i_ack, d_ack, m_req, m_we, m_ready, m_rvalid;
  logic [XLEN-1:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [XLEN/8-1:0] m_be;
  logic mdl_rdy = 0, mdl_rv = 0, man_rv = 0;
  int rdy_lat = 0, resp_lat = 1, total = 0, bad = 0;
  typedef struct {logic is_d; logic chk; logic [XLEN-1:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  assign m_ready  = mdl_rdy;
  assign m_rvalid = mdl_rv | man_rv;
  always #5 clk = ~clk;
  mem_arbiter #(.XLEN(XLEN), .MAX_STREAK(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_ready(m_ready), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );
  function automatic void check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction
  function automatic exp_t ex(input logic is_d, input logic chk, input logic [XLEN-1:0] data);
    ex.is_d = is_d;
    ex.chk  = chk;
    ex.data = data;
  endfunction
  function automatic logic [XLEN-1:0] mem_rd(input logic [XLEN-1:0] a);
    return a == 32'h100 ? 32'h0000_0013 : a == 32'h300 ? 32'h1122_3344 : 32'hBAD0_BAD0;
  endfunction
  // memory model: ready after rdy_lat cycles of m_req, response resp_lat cycles after acceptance
  logic acc = 0, pend = 0;
  logic [XLEN-1:0] paddr = 0;
  int rcnt = 0, wcnt = 0;
  always @(negedge clk) begin
    acc = m_req && m_ready && reset_n;
    if (acc) paddr = m_addr;
  end
  always @(posedge clk) begin
    #1;
    mdl_rv = 0;
    if (!reset_n) begin
      pend = 0;
      wcnt = 0;
      mdl_rdy = 0;
    end else begin
      if (acc) begin
        pend = 1;
        rcnt = 0;
      end
      if (pend) begin
        rcnt++;
        if (rcnt == resp_lat) begin
          mdl_rv = 1;
          m_rdata = mem_rd(paddr);
          pend = 0;
        end
      end
      mdl_rdy = m_req && wcnt >= rdy_lat;
      wcnt = m_req ? wcnt + 1 : 0;
    end
  end
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (sb.size() == 0) check("spurious_ack", {30'b0, i_ack, d_ack}, 32'h0);
      else begin
        e = sb.pop_front();
        check("ack_port", {30'b0, i_ack, d_ack}, {30'b0, !e.is_d, e.is_d});
        if (e.chk) check("ack_rdata", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    check(name, sb.size(), 32'h0);
    sb.delete();
  endtask
  task automatic chk_m(input string n, input logic req, input logic we, input logic [3:0] be,
                       input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata);
    check({n, ".m_req"}, m_req, req);
    check({n, ".m_we"}, m_we, we);
    check({n, ".m_be"}, m_be, be);
    check({n, ".m_addr"}, m_addr, addr);
    check({n, ".m_wdata"}, m_wdata, wdata);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_m("rst", 0, 0, 0, 0, 0);
    check("rst_ack", {30'b0, i_ack, d_ack}, 32'h0);
    @(posedge clk);
    #3 reset_n = 1;
    // store with the memory stalling three cycles
    cyc();
    rdy_lat = 3;
    resp_lat = 2;
    sb.push_back(ex(1'b1, 1'b0, 32'h0));
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk) check("st_lat", m_req, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_m($sformatf("st_hold%0d", k), 1, 1, 4'b0011, 32'h2000, 32'hDEAD_BEEF);
    end
    @(negedge clk) check("st_wait", m_req, 32'h0);
    drain("st_drain");
    d_req = 0; d_we = 0;
    // lone fetch
    rdy_lat = 0;
    resp_lat = 2;
    sb.push_back(ex(1'b0, 1'b1, 32'h13));
    i_req = 1; i_addr = 32'h100;
    @(negedge clk) check("if_lat", m_req, 32'h0);
    @(negedge clk) chk_m("if_issue", 1, 0, 0, 32'h100, 0);
    drain("if_drain");
    i_req = 0;
    // stray response while idle
    cyc();
    man_rv = 1;
    @(negedge clk) check("idle_rv_ack", {30'b0, i_ack, d_ack}, 32'h0);
    cyc();
    man_rv = 0;
    @(negedge clk) check("idle_rv_state", m_req, 32'h0);
    // stray response while issuing
    cyc();
    rdy_lat = 3;
    resp_lat = 1;
    sb.push_back(ex(1'b1, 1'b1, 32'h1122_3344));
    d_req = 1; d_addr = 32'h300;
    cyc();
    man_rv = 1;
    @(negedge clk);
    check("issue_rv_ack", {30'b0, i_ack, d_ack}, 32'h0);
    check("issue_rv_req", m_req, 32'h1);
    cyc();
    man_rv = 0;
    @(negedge clk) check("issue_rv_hold", m_req, 32'h1);
    drain("issue_rv_drain");
    d_req = 0;
    // both held: D,D,D,D,I,D,D,D,D leaves the streak saturated
    rdy_lat = 0;
    resp_lat = 1;
    for (int k = 0; k < 9; k++)
      sb.push_back(k == 4 ? ex(1'b0, 1'b1, 32'h13) : ex(1'b1, 1'b1, 32'h1122_3344));
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h300;
    drain("streak_drain");
    i_req = 0;
    for (int k = 0; k < 10; k++) sb.push_back(ex(1'b1, 1'b1, 32'h1122_3344));
    drain("donly_drain");
    i_req = 1;
    sb.push_back(ex(1'b1, 1'b1, 32'h1122_3344));
    drain("conflict_d_drain");
    d_req = 0;
    sb.push_back(ex(1'b0, 1'b1, 32'h13));
    drain("conflict_i_drain");
    i_req = 0;
    // reset while a store waits for its response
    cyc();
    resp_lat = 4;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h400; d_wdata = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("mid_wait_req", m_req, 32'h0);
    check("mid_wait_addr", m_addr, 32'h400);
    reset_n = 0; d_req = 0; d_we = 0;
    #1 chk_m("mid_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 reset_n = 1;
    cyc();
    man_rv = 1;
    @(negedge clk) check("mid_rv_ack", {30'b0, i_ack, d_ack}, 32'h0);
    cyc();
    man_rv = 0;
    @(negedge clk) chk_m("mid_post", 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
